// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared state enum and instruction encodings for the WISC memory sequencer
//
// Contents:
//   seq_state_e  - sequencer state encoding
//   NOP_INSTR    - instruction word held in the instruction register out of reset
//   OP_*         - opcode field values (instr[15:11]) of the instructions that touch memory or stop the core
//   is_mem_wait  - true for the states in which the sequencer is waiting on the memory
package wisc_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_F_REQ  = 3'd1,
        S_F_WAIT = 3'd2,
        S_DECODE = 3'd3,
        S_D_REQ  = 3'd4,
        S_D_WAIT = 3'd5,
        S_COMMIT = 3'd6,
        S_HALT   = 3'd7
    } seq_state_e;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_STU  = 5'b10011;

    // States in which progress depends on the memory; only these are timed.
    function automatic logic is_mem_wait(input seq_state_e s);
        return (s == S_F_REQ) || (s == S_F_WAIT) || (s == S_D_REQ) || (s == S_D_WAIT);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - bounded cycle counter that flags a stalled memory access
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - return the count to zero (takes priority over en)
//   en          - count one cycle
//   expired     - count has reached TIMEOUT-1
module mem_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturate at LAST so a caller that ignores expired never sees a wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_seq_ctrl.sv
// rtl/mem_seq_ctrl.sv - multicycle fetch/data/commit sequencer around one shared memory port
//
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   pc_addr, data_addr, data_wdata - fetch address, data address and store data from the datapath
//   dec_mem_rd, dec_mem_wr, dec_halt - decode of the held instruction
//   mem_rdata, mem_busy, mem_done  - memory response side
//   mem_addr, mem_wdata, mem_rd, mem_wr - memory request side
//   instr, load_data               - registered instruction and load result
//   commit                         - one-cycle PC / register-file write enable
//   halted, err_timeout            - sticky stop and memory-timeout flags
module mem_seq_ctrl
    import wisc_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              dec_mem_rd,
    input  logic              dec_mem_wr,
    input  logic              dec_halt,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] load_data,
    output logic              commit,
    output logic              halted,
    output logic              err_timeout
);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              commit_q, commit_d;
    logic              halted_q, halted_d;
    logic              err_timeout_q, err_timeout_d;

    logic              expired;
    logic              wr_access;
    logic              rd_access;

    // A store that is also flagged as a load is performed as a write only.
    assign wr_access = dec_mem_wr;
    assign rd_access = dec_mem_rd && !dec_mem_wr;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_d != state_q),
        .en      (is_mem_wait(state_q)),
        .expired (expired)
    );

    // In each timed state progress is checked before expiry, so a response in
    // the last allowed cycle still completes normally.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        load_data_d   = load_data_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            S_RESET:  state_d = S_F_REQ;
            S_F_REQ: begin
                if (!mem_busy) begin
                    state_d = S_F_WAIT;
                end else if (expired) begin
                    state_d       = S_HALT;
                    err_timeout_d = 1'b1;
                end
            end
            S_F_WAIT: begin
                if (mem_done) begin
                    instr_d = mem_rdata;
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d       = S_HALT;
                    err_timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_halt) begin
                    state_d = S_HALT;
                end else if (dec_mem_rd || dec_mem_wr) begin
                    state_d = S_D_REQ;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_D_REQ: begin
                if (!mem_busy) begin
                    state_d = S_D_WAIT;
                end else if (expired) begin
                    state_d       = S_HALT;
                    err_timeout_d = 1'b1;
                end
            end
            S_D_WAIT: begin
                if (mem_done) begin
                    if (rd_access) begin
                        load_data_d = mem_rdata;
                    end
                    state_d = S_COMMIT;
                end else if (expired) begin
                    state_d       = S_HALT;
                    err_timeout_d = 1'b1;
                end
            end
            S_COMMIT: state_d = S_F_REQ;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
        commit_d = (state_d == S_COMMIT);
        halted_d = halted_q || (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RESET;
            instr_q       <= DATA_W'(NOP_INSTR);
            load_data_q   <= '0;
            commit_q      <= 1'b0;
            halted_q      <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            load_data_q   <= load_data_d;
            commit_q      <= commit_d;
            halted_q      <= halted_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Request lines are decoded from the current state rather than registered:
    // the PC is written on the commit edge, and the fetch that follows must
    // present that new PC in its very first request cycle.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_F_REQ: begin
                mem_rd   = 1'b1;
                mem_addr = pc_addr;
            end
            S_D_REQ: begin
                mem_addr = data_addr;
                mem_rd   = rd_access;
                mem_wr   = wr_access;
                if (wr_access) begin
                    mem_wdata = data_wdata;
                end
            end
            default: ;
        endcase
    end

    assign instr       = instr_q;
    assign load_data   = load_data_q;
    assign commit      = commit_q;
    assign halted      = halted_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb/tb_mem_seq_ctrl.sv - self-checking bench for mem_seq_ctrl
module tb_mem_seq_ctrl;
    import wisc_pkg::*;

    localparam int K_FETCH  = 0;
    localparam int K_RD     = 1;
    localparam int K_WR     = 2;
    localparam int K_COMMIT = 3;
    localparam int K_HALT   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_addr;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic        dec_halt;
    logic [15:0] mem_rdata;
    logic        mem_busy;
    logic        mem_done;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] instr;
    logic [15:0] load_data;
    logic        commit;
    logic        halted;
    logic        err_timeout;

    always #5 clk = ~clk;

    mem_seq_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_addr     (pc_addr),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .dec_mem_rd  (dec_mem_rd),
        .dec_mem_wr  (dec_mem_wr),
        .dec_halt    (dec_halt),
        .mem_rdata   (mem_rdata),
        .mem_busy    (mem_busy),
        .mem_done    (mem_done),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .instr       (instr),
        .load_data   (load_data),
        .commit      (commit),
        .halted      (halted),
        .err_timeout (err_timeout)
    );

    // Datapath stand-in: decode and operand values follow the held instruction.
    logic [4:0] opc;
    assign opc        = instr[15:11];
    assign dec_halt   = (opc == OP_HALT);
    assign dec_mem_rd = (opc == OP_LD);
    assign dec_mem_wr = (opc == OP_ST) || (opc == OP_STU);
    assign data_addr  = dec_mem_rd ? 16'h0100 : 16'h0200;
    assign data_wdata = 16'h1234;

    logic [15:0] mem [logic [15:0]];

    function automatic logic [15:0] mrd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0800;
    endfunction

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] m_load;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Expected transactions for the instruction stored at pc, from the
    // sequencing rules: fetch, optional data access, then commit (or halt).
    task automatic plan(input logic [15:0] pc, input int busy, input bit first);
        logic [15:0] w;
        logic [4:0]  op;
        int          lat;
        ev_t         e;
        w = mrd(pc);
        op = w[15:11];
        e.kind = K_FETCH; e.a = pc; e.b = 16'h0; e.lat = 0;
        exp_q.push_back(e);
        if (op == OP_HALT) begin
            e.kind = K_HALT; e.a = pc; e.b = 16'h0;
            exp_q.push_back(e);
            return;
        end
        lat = 4;
        if (op == OP_LD) begin
            e.kind = K_RD; e.a = 16'h0100; e.b = 16'h0;
            exp_q.push_back(e);
            m_load = mrd(16'h0100);
            lat = 6;
        end else if (op == OP_ST || op == OP_STU) begin
            e.kind = K_WR; e.a = 16'h0200; e.b = 16'h1234;
            exp_q.push_back(e);
            lat = 6 + busy;
        end
        e.kind = K_COMMIT; e.a = w; e.b = m_load; e.lat = first ? 0 : lat;
        exp_q.push_back(e);
    endtask

    // ---------------- memory responder ----------------
    int          busy_wr_left = 0;
    int          done_delay = 1;
    bit          withhold = 1'b0;
    bit          inject = 1'b0;
    bit          pend = 1'b0;
    bit          had_pend;
    int          wait_cnt = 0;
    logic [15:0] pend_data = 16'h0;
    logic [15:0] last_acc_addr = 16'hFFFF;

    initial begin
        mem_busy  = 1'b0;
        mem_done  = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            had_pend = pend;
            mem_done = 1'b0;
            if (pend) begin
                if (wait_cnt == 0) begin
                    pend = 1'b0;
                    if (!withhold) begin
                        mem_done  = 1'b1;
                        mem_rdata = pend_data;
                    end
                end else begin
                    wait_cnt--;
                end
            end
            if (inject) begin
                mem_done  = 1'b1;
                mem_rdata = 16'hAAAA;
                inject    = 1'b0;
            end
            if (rst_n && commit) pc_addr = pc_addr + 16'd2;
            mem_busy = 1'b0;
            if (rst_n && (mem_rd || mem_wr)) begin
                if (had_pend) begin
                    mem_busy = 1'b1;
                end else if (mem_wr && busy_wr_left > 0) begin
                    mem_busy = 1'b1;
                    busy_wr_left--;
                end else begin
                    pend      = 1'b1;
                    wait_cnt  = done_delay - 1;
                    pend_data = mem_rd ? mrd(mem_addr) : 16'h0;
                    if (mem_wr) mem[mem_addr] = mem_wdata;
                    last_acc_addr = mem_addr;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int          cyc = 0;
    int          last_commit_cyc = 0;
    int          n_commit = 0;
    int          acc_cyc_last = 0;
    int          halt_cyc = 0;
    int          commit_cycs[$];
    logic        prev_busy_req, prev_acc, prev_halted, prev_rd, prev_wr;
    logic [15:0] prev_addr, prev_wdata;

    initial begin
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                prev_busy_req = 1'b0;
                prev_acc      = 1'b0;
                prev_halted   = 1'b0;
                continue;
            end
            chk("one_req", {31'b0, mem_rd & mem_wr}, 32'd0);
            if (prev_busy_req) begin
                chk("hold_rd", {31'b0, mem_rd}, {31'b0, prev_rd});
                chk("hold_wr", {31'b0, mem_wr}, {31'b0, prev_wr});
                chk("hold_addr", {16'b0, mem_addr}, {16'b0, prev_addr});
                chk("hold_wdata", {16'b0, mem_wdata}, {16'b0, prev_wdata});
            end
            if (prev_acc) chk("req_one_cycle", {31'b0, mem_rd | mem_wr}, 32'd0);
            if (halted) chk("halt_quiet", {29'b0, mem_rd, mem_wr, commit}, 32'd0);
            if ((mem_rd || mem_wr) && !mem_busy) begin
                ok = exp_q.size() > 0;
                chk("req_expected", {31'b0, ok}, 32'd1);
                if (ok) begin
                    e = exp_q.pop_front();
                    chk("req_type", {30'b0, mem_rd, mem_wr}, (e.kind == K_WR) ? 32'd1 :
                        ((e.kind == K_FETCH || e.kind == K_RD) ? 32'd2 : 32'd3));
                    chk("req_addr", {16'b0, mem_addr}, {16'b0, e.a});
                    if (e.kind == K_WR) chk("req_wdata", {16'b0, mem_wdata}, {16'b0, e.b});
                end
                acc_cyc_last = cyc;
            end
            if (commit) begin
                ok = exp_q.size() > 0;
                chk("commit_expected", {31'b0, ok}, 32'd1);
                if (ok) begin
                    e = exp_q.pop_front();
                    chk("commit_kind", e.kind, K_COMMIT);
                    chk("commit_instr", {16'b0, instr}, {16'b0, e.a});
                    chk("commit_load_data", {16'b0, load_data}, {16'b0, e.b});
                    if (e.lat != 0) chk("commit_gap", cyc - last_commit_cyc, e.lat);
                end
                last_commit_cyc = cyc;
                commit_cycs.push_back(cyc);
                n_commit++;
            end
            if (halted && !prev_halted) begin
                ok = exp_q.size() > 0;
                chk("halt_expected", {31'b0, ok}, 32'd1);
                if (ok) begin
                    e = exp_q.pop_front();
                    chk("halt_kind", e.kind, K_HALT);
                    chk("halt_err", {31'b0, err_timeout}, {31'b0, e.b[0]});
                end
                halt_cyc = cyc;
            end
            prev_busy_req = (mem_rd || mem_wr) && mem_busy;
            prev_acc      = (mem_rd || mem_wr) && !mem_busy;
            prev_halted   = halted;
            prev_rd       = mem_rd;
            prev_wr       = mem_wr;
            prev_addr     = mem_addr;
            prev_wdata    = mem_wdata;
        end
    end

    // ---------------- directed sequence ----------------
    task automatic check_reset_vals(input string tag);
        chk({tag, "_instr"}, {16'b0, instr}, 32'h0800);
        chk({tag, "_load_data"}, {16'b0, load_data}, 32'h0);
        chk({tag, "_mem_addr"}, {16'b0, mem_addr}, 32'h0);
        chk({tag, "_mem_wdata"}, {16'b0, mem_wdata}, 32'h0);
        chk({tag, "_flags"}, {27'b0, mem_rd, mem_wr, commit, halted, err_timeout}, 32'h0);
    endtask

    task automatic wait_halted(input int maxc, input string name);
        for (int i = 0; i < maxc && !halted; i++) begin
            @(negedge clk);
            #2;
        end
        chk(name, {31'b0, halted}, 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_load  = 16'h0;
        mem[16'h0000] = 16'h4101;
        mem[16'h0002] = 16'h4222;
        mem[16'h0004] = 16'h8841;
        mem[16'h0006] = 16'h8062;
        mem[16'h0008] = 16'h0000;
        mem[16'h000A] = 16'h4333;
        mem[16'h0100] = 16'hBEEF;
        pc_addr = 16'h0000;
        rst_n   = 1'b0;
        #12;
        check_reset_vals("rst0");

        // Program: ADDI, ADDI, LD, ST (busy 3 cycles), HALT.
        busy_wr_left = 3;
        plan(16'h0000, 0, 1'b1);
        plan(16'h0002, 0, 1'b0);
        plan(16'h0004, 0, 1'b0);
        plan(16'h0006, 3, 1'b0);
        plan(16'h0008, 0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_halted(200, "p1_halt_reached");
        repeat (5) @(negedge clk);
        #2;
        chk("p1_commits", n_commit, 4);
        if (commit_cycs.size() == 4) begin
            chk("p1_gap_addi", commit_cycs[1] - commit_cycs[0], 4);
            chk("p1_gap_ld", commit_cycs[2] - commit_cycs[1], 6);
            chk("p1_gap_st", commit_cycs[3] - commit_cycs[2], 9);
        end
        chk("p1_load_data", {16'b0, load_data}, 32'hBEEF);
        chk("p1_store_mem", {16'b0, mrd(16'h0200)}, 32'h1234);
        chk("p1_instr_halt", {16'b0, instr}, 32'h0000);
        chk("p1_err", {31'b0, err_timeout}, 32'd0);
        chk("p1_pc_held", {16'b0, pc_addr}, 32'h0008);
        chk("p1_queue_empty", exp_q.size(), 0);

        // Fetch response withheld: timeout after 64 cycles in F_WAIT.
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        commit_cycs.delete();
        n_commit = 0;
        m_load   = 16'h0;
        pc_addr  = 16'h000A;
        withhold = 1'b1;
        begin
            ev_t e;
            e.kind = K_FETCH; e.a = 16'h000A; e.b = 16'h0; e.lat = 0;
            exp_q.push_back(e);
            e.kind = K_HALT; e.b = 16'h0001;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_halted(300, "p2_halt_reached");
        chk("p2_err_timeout", {31'b0, err_timeout}, 32'd1);
        chk("p2_timeout_cycles", halt_cyc - acc_cyc_last, 65);
        withhold = 1'b0;
        inject   = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("p2_late_done_instr", {16'b0, instr}, 32'h0800);
        chk("p2_still_halted", {30'b0, halted, err_timeout}, 32'd3);
        chk("p2_no_commit", n_commit, 0);
        chk("p2_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a load's data wait.
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_load     = 16'h0;
        pc_addr    = 16'h0004;
        done_delay = 4;
        plan(16'h0004, 0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                #2;
                seen = (last_acc_addr == 16'h0100);
            end
            chk("p3_data_read_seen", {31'b0, seen}, 32'd1);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_dwait");
        exp_q.delete();
        done_delay = 1;
        pc_addr    = 16'h0000;
        m_load     = 16'h0;
        n_commit   = 0;
        plan(16'h0000, 0, 1'b1);
        plan(16'h0002, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 100 && n_commit < 2; i++) begin
            @(negedge clk);
            #2;
        end
        chk("p3_commits", n_commit, 2);
        chk("p3_queue_empty", exp_q.size(), 0);
        chk("p3_instr", {16'b0, instr}, 32'h4222);
        chk("p3_load_data", {16'b0, load_data}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_seq_ctrl.md
Name: mem_seq_ctrl

Overview:
- Multicycle sequencer that wraps the single-cycle WISC datapath around one shared, single-ported, variable-latency unified memory.
- Fetches the instruction at the PC and holds it for decode.
- If the decoded instruction accesses memory (LD, ST, STU), performs that data access.
- Then issues a one-cycle commit that enables the PC and register-file writes.
- Handles halt and memory timeout by parking in a halted state.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory/instruction data width.
- TIMEOUT, 64, maximum cycles to wait for mem_done before a timeout error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pc_addr  in  ADDR_W  current PC from the datapath
- data_addr  in  ADDR_W  ALU result used as the data address
- data_wdata  in  DATA_W  store data (read2data)
- dec_mem_rd  in  1  decoded MemToReg (load)
- dec_mem_wr  in  1  decoded MemWrite (ST/STU)
- dec_halt  in  1  decoded halt
- mem_rdata  in  DATA_W  memory read data
- mem_busy  in  1  memory cannot accept a request this cycle
- mem_done  in  1  pulse: outstanding request has completed
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd  out  1  read request
- mem_wr  out  1  write request
- instr  out  DATA_W  registered instruction fed to control and datapath
- load_data  out  DATA_W  registered load result
- commit  out  1  one-cycle write enable for the PC and register file
- halted  out  1  sticky: core stopped
- err_timeout  out  1  sticky: memory timeout occurred

Behaviour:
- Reset (async, rst_n low): state=RESET.
- Reset values of outputs:
  - instr = 16'h0800 (NOP)
  - load_data = 0
  - mem_rd = mem_wr = commit = halted = err_timeout = 0
  - mem_addr = mem_wdata = 0
  - timeout counter = 0
- States: RESET, F_REQ, F_WAIT, DECODE, D_REQ, D_WAIT, COMMIT, HALT.
- RESET -> F_REQ unconditionally on the first clock after reset deasserts.
- F_REQ:
  - Drive mem_rd=1 and mem_addr=pc_addr.
  - When mem_busy=0 the request is accepted -> F_WAIT.
  - Otherwise hold mem_rd and mem_addr stable.
- F_WAIT:
  - mem_rd=0.
  - On mem_done: instr <= mem_rdata -> DECODE.
- DECODE (exactly 1 cycle; control decodes instr combinationally). Priority, highest first:
  - dec_halt=1 -> HALT.
  - dec_mem_rd or dec_mem_wr -> D_REQ.
  - Otherwise -> COMMIT.
- D_REQ:
  - mem_addr=data_addr.
  - mem_wr=dec_mem_wr and mem_wdata=data_wdata; mem_rd=dec_mem_rd when dec_mem_wr=0.
  - If both dec_mem_rd and dec_mem_wr are set, the write wins.
  - Accepted when mem_busy=0 -> D_WAIT.
- D_WAIT: on mem_done, load_data <= mem_rdata if the access was a read -> COMMIT.
- COMMIT: commit=1 for exactly one cycle -> F_REQ. The PC updates on this edge, so the next fetch uses the new pc_addr.
- HALT:
  - Absorbing; halted=1, no memory requests, commit never asserted.
  - Exit only by reset.
  - Halt never asserts commit, so the PC stays on the halt instruction.
- Timeout counter:
  - Counts cycles spent in F_REQ, F_WAIT, D_REQ, D_WAIT.
  - Clears on every state change.
  - On reaching TIMEOUT-1 without progress: err_timeout=1, halted=1 -> HALT.
  - A mem_done arriving in the same cycle as the timeout wins; there is no error.
- A mem_done outside F_WAIT/D_WAIT is ignored.
- Requests are single-outstanding; at most one of mem_rd/mem_wr is high in any cycle.
- Latency:
  - Non-memory instruction with 1-cycle memory (mem_done the cycle after accept): F_REQ, F_WAIT, DECODE, COMMIT = 4 cycles per instruction.
  - Load/store adds 2 cycles.
- Reset mid-transaction: all state is cleared immediately. A memory response arriving after reset is ignored because the state is F_REQ or RESET.

Decomposition:
- Shared package wisc_pkg holds:
  - the state enum;
  - the NOP encoding 16'h0800;
  - the opcode constants OP_HALT=5'b00000, OP_ST=5'b10000, OP_LD=5'b10001, OP_STU=5'b10011 (for bench checking).
- One sub-module, mem_timeout_ctr: a TIMEOUT-bounded counter with clear/enable and an expired flag.

Test Plan:
- ADDI stream, memory done 1 cycle after accept, pc 0x0000 -> 0x0002:
  - commit pulses every 4 cycles;
  - mem_rd high only in F_REQ;
  - instr tracks memory.
- LD at pc 0x0004, data_addr=0x0100, mem_rdata=0xBEEF:
  - read at 0x0004, then read at 0x0100;
  - load_data=0xBEEF at commit;
  - 6 cycles total.
- ST data_addr=0x0200, data_wdata=0x1234, mem_busy high for 3 cycles:
  - mem_wr, mem_addr, mem_wdata held stable for those 3 cycles;
  - accepted on the 4th cycle;
  - single commit.
- Fetch returns 16'h0000 (HALT):
  - DECODE -> HALT;
  - halted=1;
  - no further mem_rd;
  - commit never asserted.
- mem_done withheld for 64 cycles in F_WAIT:
  - err_timeout=1 and halted=1;
  - a later mem_done is ignored.
- rst_n low during D_WAIT:
  - outputs return to reset values asynchronously;
  - after release, the first request is a fetch at the current pc_addr.
